// File: rtl/timer_pkg.sv
// Shared types and helpers for the modulo-N down-counter/timer.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_AUTO    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Out-of-range requests (0 or >= n) fall back to the full modulus n-1.
    function automatic int eff_start(int load_val, int n);
        return ((load_val >= 1) && (load_val <= n - 1)) ? load_val : n - 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CE down to one TICK every PRESC-th enabled cycle; CLR restarts the division.
module tick_prescaler #(
    parameter int PRESC = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic CLR,
    output logic TICK
);

    localparam int             CW   = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESC - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            cnt <= '0;
        end else if (CE) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign TICK = CE && (cnt == LAST);

endmodule

// File: rtl/timer_mod_n_down.sv
// Loadable modulo-N down-counter with terminal-count pulse, auto-reload or one-shot.
// Define TIMER_PRESCALER_EN to tick only on every PRESC-th CE-high cycle.
module timer_mod_n_down
    import timer_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = $clog2(N),
    parameter int PRESC = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             START,
    input  logic             STOP,
    input  logic [WIDTH:0]   LOAD_VAL,
    input  logic             MODE,
    output logic [WIDTH:0]   y,
    output logic             TC,
    output logic             BUSY
);

    typedef logic [WIDTH:0] cnt_t;

    state_t state, state_next;
    cnt_t   y_next, load_q, load_next, start_val;
    logic   mode_q, mode_next, tc_next, tick;

    if (PRESC < 1) begin : g_bad_presc
        $error("timer_mod_n_down: PRESC must be at least 1");
    end

    assign start_val = cnt_t'(eff_start(32'(LOAD_VAL), N));

`ifdef TIMER_PRESCALER_EN
    // Division restarts on any START/STOP and whenever the timer drops back to IDLE.
    logic presc_clr;
    assign presc_clr = START || STOP || (state_next == IDLE);

    tick_prescaler #(.PRESC(PRESC)) u_tick_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .CE   (CE && (state == RUN)),
        .CLR  (presc_clr),
        .TICK (tick)
    );
`else
    assign tick = CE;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        y_next     = y;
        load_next  = load_q;
        mode_next  = mode_q;
        tc_next    = 1'b0;
        unique case (state)
            IDLE: begin
                y_next = '0;
                if (START && !STOP) begin
                    state_next = RUN;
                    y_next     = start_val;
                    load_next  = start_val;
                    mode_next  = MODE;
                end
            end
            RUN: begin
                if (STOP) begin
                    state_next = IDLE;
                    y_next     = '0;
                end else if (START) begin
                    y_next    = start_val;
                    load_next = start_val;
                    mode_next = MODE;
                end else if (tick) begin
                    if (y != '0) begin
                        y_next = y - cnt_t'(1);
                    end else begin
                        tc_next = 1'b1;
                        if (mode_q == MODE_ONESHOT) begin
                            state_next = IDLE;
                            y_next     = '0;
                        end else begin
                            y_next = load_q;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: reset is synchronous; all registers here are small control state, none is a memory.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            y      <= '0;
            TC     <= 1'b0;
            load_q <= cnt_t'(N - 1);
            mode_q <= MODE_AUTO;
        end else begin
            state  <= state_next;
            y      <= y_next;
            TC     <= tc_next;
            load_q <= load_next;
            mode_q <= mode_next;
        end
    end

    assign BUSY = (state == RUN);

endmodule
